// File: rtl/c64_cart_loader_pkg.sv
// Shared types and constants for the C64 cartridge/loader block.
package c64_cart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

    localparam int          CART_8K_AW        = 13;
    localparam int          CART_16K_AW       = 14;
    localparam logic [15:0] DEFAULT_LOAD_BASE = 16'h0801;

endpackage

// File: rtl/c64_cart_loader_if.sv
// Expansion-port bundle between the C64 core (master) and the cartridge/loader (slave).
interface c64_cart_loader_if;

    logic        phi2_i;
    logic [15:0] addr_i;
    logic        roml_i;
    logic        romh_i;
    logic        ba_i;
    logic        start_load_i;

    logic [7:0]  data_o;
    logic [15:0] load_addr_o;
    logic        dma_o;
    logic        rw_o;
    logic        loading_o;
    logic        game_n_o;
    logic        exrom_n_o;

    modport master (
        output phi2_i, addr_i, roml_i, romh_i, ba_i, start_load_i,
        input  data_o, load_addr_o, dma_o, rw_o, loading_o, game_n_o, exrom_n_o
    );

    modport slave (
        input  phi2_i, addr_i, roml_i, romh_i, ba_i, start_load_i,
        output data_o, load_addr_o, dma_o, rw_o, loading_o, game_n_o, exrom_n_o
    );

endinterface

// File: rtl/c64_cart_loader_rom.sv
// Byte-wide initialised memory. Registered read (with enable) for the cartridge
// ROM, combinational read for the program image. Bytes at or beyond SIZE read 8'hFF.
module cart_rom #(
    parameter string FILE     = "",
    parameter int    AW       = 13,
    parameter int    SIZE     = 8192,
    parameter bit    READ_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a,
    input  logic          en,
    output logic [7:0]    d
);

    localparam logic [AW:0] SIZE_W = (AW + 1)'(SIZE);

    logic [7:0] mem [2**AW];
    logic       in_range;
    logic [7:0] rd_data;

    assign in_range = ({1'b0, a} < SIZE_W);
    assign rd_data  = in_range ? mem[a] : 8'hFF;

    generate
        if (READ_REG) begin : g_reg
            logic [7:0] d_q;

            // Output register follows the array only while selected, otherwise holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q <= 8'h00;
                end else if (en) begin
                    d_q <= rd_data;
                end
            end

            assign d = d_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst;
            assign d = en ? rd_data : 8'hFF;
        end
    endgenerate

endmodule

// File: rtl/c64_cart_loader.sv
// Cartridge ROM on ROML/ROMH plus a DMA loader that streams a PRG image into C64 RAM.
//
// state | meaning
// IDLE  | bus released, ROM data register drives data_o
// LOAD  | DMA asserted, one image byte written per phi2 rise while BA is low
module c64_cart_loader
    import c64_cart_pkg::*;
#(
    parameter string       ROM_FILE  = "cart.hex",
    parameter int          ROM_AW    = CART_8K_AW,
    parameter int          ROM_SIZE  = 8192,
    parameter string       IMG_FILE  = "prog.hex",
    parameter int          IMG_AW    = 16,
    parameter int          IMG_SIZE  = 47687,
    parameter logic [15:0] LOAD_BASE = DEFAULT_LOAD_BASE,
    parameter int          IMG_SKIP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    c64_cart_loader_if.slave  bus
);

    localparam logic [IMG_AW-1:0] SKIP_W = IMG_AW'(IMG_SKIP);
    localparam logic [IMG_AW-1:0] LAST_W = IMG_AW'(IMG_SIZE - 1);

    load_state_e       state_q, state_d;
    logic [IMG_AW-1:0] offset_q, offset_d;
    logic [15:0]       load_addr_q, load_addr_d;
    logic              phi2_q;
    logic              phi2_rise;
    logic              loading;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_idx;
    logic [7:0]        rom_data;
    logic [7:0]        img_data;
    logic              unused_addr_hi;

    // Upper address bits are implied by ROML/ROMH decoding in the C64.
    assign unused_addr_hi = ^bus.addr_i[15:13];

    generate
        if (ROM_AW == CART_16K_AW) begin : g_16k
            assign rom_idx = {bus.romh_i, bus.addr_i[12:0]};
        end else begin : g_8k
            assign rom_idx = bus.addr_i[12:0];
        end
    endgenerate

    assign rom_en = bus.roml_i | bus.romh_i;

    cart_rom #(
        .FILE     (ROM_FILE),
        .AW       (ROM_AW),
        .SIZE     (ROM_SIZE),
        .READ_REG (1'b1)
    ) u_rom (
        .clk (clk),
        .rst (reset),
        .a   (rom_idx),
        .en  (rom_en),
        .d   (rom_data)
    );

    cart_rom #(
        .FILE     (IMG_FILE),
        .AW       (IMG_AW),
        .SIZE     (IMG_SIZE),
        .READ_REG (1'b0)
    ) u_img (
        .clk (clk),
        .rst (reset),
        .a   (offset_q),
        .en  (loading),
        .d   (img_data)
    );

    assign phi2_rise = bus.phi2_i & ~phi2_q;

    // Loader next state: arm on a phi2 rise with a request, advance on each granted phi2 rise.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        load_addr_d = load_addr_q;
        loading     = 1'b0;
        case (state_q)
            IDLE: begin
                if (phi2_rise && bus.start_load_i) begin
                    state_d     = LOAD;
                    offset_d    = SKIP_W;
                    load_addr_d = LOAD_BASE;
                end
            end
            LOAD: begin
                loading = 1'b1;
                if (phi2_rise && !bus.ba_i) begin
                    // '>=' also ends a load whose skip already lies past the image.
                    if (offset_q >= LAST_W) begin
                        state_d = IDLE;
                    end else begin
                        offset_d    = offset_q + IMG_AW'(1);
                        load_addr_d = load_addr_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, offset, destination address and phi2 sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            load_addr_q <= 16'h0000;
            phi2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            load_addr_q <= load_addr_d;
            phi2_q      <= bus.phi2_i;
        end
    end

    assign bus.data_o      = loading ? img_data : rom_data;
    assign bus.load_addr_o = load_addr_q;
    assign bus.dma_o       = loading;
    assign bus.loading_o   = loading;
    assign bus.rw_o        = ~loading;
    assign bus.game_n_o    = (ROM_AW == CART_8K_AW);
    assign bus.exrom_n_o   = 1'b0;

endmodule

// File: tb/tb_c64_cart_loader.sv
// Bench for c64_cart_loader: three builds (8K/basic load, 16K/address wrap,
// skip past image end) sharing one clock and bus stimulus.
module tb_c64_cart_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk    = 1'b0;
    logic        rst_a  = 1'b0;
    logic        rst_bc = 1'b0;
    logic        phi2   = 1'b0;
    logic [15:0] addr   = 16'h0000;
    logic        roml   = 1'b0;
    logic        romh   = 1'b0;
    logic        ba     = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        start_c = 1'b0;

    int vec_cnt     = 0;
    int miscompares = 0;

    xfer_t exp_a[$];
    xfer_t exp_b[$];
    xfer_t exp_c[$];

    logic [7:0] rom_a [8192];
    logic [7:0] rom_b [16384];
    logic [7:0] img_a [256];
    logic [7:0] img_b [256];
    logic [7:0] img_c [256];

    always #5 clk = ~clk;

    c64_cart_loader_if ifa ();
    c64_cart_loader_if ifb ();
    c64_cart_loader_if ifc ();

    assign ifa.phi2_i = phi2;  assign ifb.phi2_i = phi2;  assign ifc.phi2_i = phi2;
    assign ifa.addr_i = addr;  assign ifb.addr_i = addr;  assign ifc.addr_i = addr;
    assign ifa.roml_i = roml;  assign ifb.roml_i = roml;  assign ifc.roml_i = roml;
    assign ifa.romh_i = romh;  assign ifb.romh_i = romh;  assign ifc.romh_i = romh;
    assign ifa.ba_i   = ba;    assign ifb.ba_i   = ba;    assign ifc.ba_i   = ba;
    assign ifa.start_load_i = start_a;
    assign ifb.start_load_i = start_b;
    assign ifc.start_load_i = start_c;

    c64_cart_loader #(
        .ROM_FILE (""), .ROM_AW (13), .ROM_SIZE (8000),
        .IMG_FILE (""), .IMG_AW (8), .IMG_SIZE (6),
        .LOAD_BASE (16'h0801), .IMG_SKIP (2)
    ) dA (.clk (clk), .reset (rst_a), .bus (ifa));

    c64_cart_loader #(
        .ROM_FILE (""), .ROM_AW (14), .ROM_SIZE (16384),
        .IMG_FILE (""), .IMG_AW (8), .IMG_SIZE (5),
        .LOAD_BASE (16'hFFFF), .IMG_SKIP (2)
    ) dB (.clk (clk), .reset (rst_bc), .bus (ifb));

    c64_cart_loader #(
        .ROM_FILE (""), .ROM_AW (13), .ROM_SIZE (16),
        .IMG_FILE (""), .IMG_AW (8), .IMG_SIZE (3),
        .LOAD_BASE (16'h1000), .IMG_SKIP (4)
    ) dC (.clk (clk), .reset (rst_bc), .bus (ifc));

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected transfer list for one load of each build.
    task automatic push_load(input int id);
        xfer_t e;
        case (id)
            0: for (int k = 0; k < 4; k++) begin
                   e.addr = 16'h0801 + 16'(k);
                   e.data = img_a[2 + k];
                   exp_a.push_back(e);
               end
            1: for (int k = 0; k < 3; k++) begin
                   e.addr = 16'hFFFF + 16'(k);
                   e.data = img_b[2 + k];
                   exp_b.push_back(e);
               end
            default: begin
                   e.addr = 16'h1000;
                   e.data = 8'hFF;
                   exp_c.push_back(e);
               end
        endcase
    endtask

    task automatic take_xfer(input int id, input logic [15:0] ad, input logic [7:0] da);
        xfer_t e;
        int    n;
        case (id)
            0:       n = exp_a.size();
            1:       n = exp_b.size();
            default: n = exp_c.size();
        endcase
        chk_val($sformatf("sb%0d_pending", id), 32'(n != 0), 32'd1);
        if (n != 0) begin
            case (id)
                0:       e = exp_a.pop_front();
                1:       e = exp_b.pop_front();
                default: e = exp_c.pop_front();
            endcase
            chk_val($sformatf("sb%0d_addr", id), 32'(ad), 32'(e.addr));
            chk_val($sformatf("sb%0d_data", id), 32'(da), 32'(e.data));
        end
    endtask

    task automatic sample_all();
        if (ifa.loading_o && !ba) take_xfer(0, ifa.load_addr_o, ifa.data_o);
        if (ifb.loading_o && !ba) take_xfer(1, ifb.load_addr_o, ifb.data_o);
        if (ifc.loading_o && !ba) take_xfer(2, ifc.load_addr_o, ifc.data_o);
    endtask

    // One phi2 pulse; the rise is taken at the posedge after it is driven.
    task automatic phi2_edge();
        @(negedge clk);
        phi2 = 1'b1;
        #1;
        sample_all();
        @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++)  rom_a[i] = 8'($urandom);
        for (int i = 0; i < 16384; i++) rom_b[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            img_a[i] = 8'($urandom);
            img_b[i] = 8'($urandom);
            img_c[i] = 8'($urandom);
        end
        rom_a[0]       = 8'h09;
        rom_a[5]       = 8'h77;
        rom_a[16'h10]  = 8'h3C;
        rom_a[16'h1F3F] = 8'h5A;
        rom_b[0]       = 8'h11;
        rom_b[5]       = 8'h22;
        rom_b[16'h2005] = 8'hC3;
        for (int i = 0; i < 8192; i++)  dA.u_rom.mem[i] = rom_a[i];
        for (int i = 0; i < 16384; i++) dB.u_rom.mem[i] = rom_b[i];
        for (int i = 0; i < 256; i++) begin
            dA.u_img.mem[i] = img_a[i];
            dB.u_img.mem[i] = img_b[i];
            dC.u_img.mem[i] = img_c[i];
        end

        #1;
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        repeat (3) @(negedge clk);
        chk_val("rst_data",    ifa.data_o, 8'h00);
        chk_val("rst_ldaddr",  ifa.load_addr_o, 16'h0000);
        chk_val("rst_dma",     ifa.dma_o, 1'b0);
        chk_val("rst_loading", ifa.loading_o, 1'b0);
        chk_val("rst_rw",      ifa.rw_o, 1'b1);
        chk_val("a_game_n",    ifa.game_n_o, 1'b1);
        chk_val("b_game_n",    ifb.game_n_o, 1'b0);
        chk_val("a_exrom_n",   ifa.exrom_n_o, 1'b0);
        chk_val("b_exrom_n",   ifb.exrom_n_o, 1'b0);
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // ROM reads
        @(negedge clk);
        roml = 1'b1;
        addr = 16'h8000;
        #1;
        chk_val("a_rom_latency", ifa.data_o, 8'h00);
        @(negedge clk);
        chk_val("a_rom_0000", ifa.data_o, rom_a[0]);
        chk_val("b_rom_bank0", ifb.data_o, rom_b[0]);
        addr = 16'h9F3F;
        @(negedge clk);
        chk_val("a_rom_1f3f", ifa.data_o, rom_a[16'h1F3F]);
        addr = 16'h9F40;
        @(negedge clk);
        chk_val("a_rom_oob", ifa.data_o, 8'hFF);
        addr = 16'h9FFF;
        @(negedge clk);
        chk_val("a_rom_top", ifa.data_o, 8'hFF);
        roml = 1'b0;
        addr = 16'h8010;
        repeat (2) @(negedge clk);
        chk_val("a_rom_hold", ifa.data_o, 8'hFF);
        romh = 1'b1;
        addr = 16'hA005;
        @(negedge clk);
        chk_val("b_rom_bank1", ifb.data_o, rom_b[16'h2005]);
        chk_val("a_rom_romh", ifa.data_o, rom_a[5]);
        romh = 1'b0;
        roml = 1'b1;
        addr = 16'h8005;
        @(negedge clk);
        chk_val("b_rom_bank0_5", ifb.data_o, rom_b[5]);
        roml = 1'b0;

        // Load on all builds, with a three-edge bus stall after the first transfer
        ba = 1'b0;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        push_load(0); push_load(1); push_load(2);
        phi2_edge();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        chk_val("a_dma_on",     ifa.dma_o, 1'b1);
        chk_val("a_loading_on", ifa.loading_o, 1'b1);
        chk_val("a_rw_write",   ifa.rw_o, 1'b0);
        chk_val("a_first_addr", ifa.load_addr_o, 16'h0801);
        chk_val("a_first_data", ifa.data_o, img_a[2]);
        chk_val("b_first_addr", ifb.load_addr_o, 16'hFFFF);
        chk_val("c_loading_on", ifc.loading_o, 1'b1);
        phi2_edge();
        chk_val("c_done_one", ifc.loading_o, 1'b0);
        ba = 1'b1;
        repeat (3) phi2_edge();
        chk_val("a_stall_addr", ifa.load_addr_o, 16'h0802);
        chk_val("a_stall_dma",  ifa.dma_o, 1'b1);
        chk_val("a_stall_data", ifa.data_o, img_a[3]);
        ba = 1'b0;
        repeat (3) phi2_edge();
        chk_val("a_done_dma",     ifa.dma_o, 1'b0);
        chk_val("a_done_loading", ifa.loading_o, 1'b0);
        chk_val("a_done_rw",      ifa.rw_o, 1'b1);
        chk_val("a_idle_mux",     ifa.data_o, rom_a[5]);
        chk_val("b_wrap_end",     ifb.load_addr_o, 16'h0001);
        chk_val("b_done_loading", ifb.loading_o, 1'b0);

        // start held through a load is ignored, then restarts on the edge after completion
        start_a = 1'b1;
        push_load(0);
        phi2_edge();
        repeat (3) phi2_edge();
        chk_val("a_ignore_start", ifa.loading_o, 1'b1);
        push_load(0);
        phi2_edge();
        chk_val("a_done_before_rs", ifa.loading_o, 1'b0);
        phi2_edge();
        start_a = 1'b0;
        chk_val("a_restarted",  ifa.loading_o, 1'b1);
        chk_val("a_restart_ad", ifa.load_addr_o, 16'h0801);
        repeat (4) phi2_edge();
        chk_val("a_restart_done", ifa.loading_o, 1'b0);

        // Reset in the middle of a load
        start_a = 1'b1;
        push_load(0);
        phi2_edge();
        start_a = 1'b0;
        repeat (2) phi2_edge();
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk_val("a_rst_dma",     ifa.dma_o, 1'b0);
        chk_val("a_rst_loading", ifa.loading_o, 1'b0);
        exp_a.delete();
        @(negedge clk);
        rst_a = 1'b0;
        start_a = 1'b1;
        push_load(0);
        phi2_edge();
        start_a = 1'b0;
        chk_val("a_post_rst_addr", ifa.load_addr_o, 16'h0801);
        repeat (4) phi2_edge();
        chk_val("a_post_rst_done", ifa.loading_o, 1'b0);

        chk_val("sb0_drained", exp_a.size(), 0);
        chk_val("sb1_drained", exp_b.size(), 0);
        chk_val("sb2_drained", exp_c.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
